wb_stream_mailbox: RTL and testbench
====================================

# wb_stream_mailbox

Wishbone slave that sits directly downstream of the SPI-to-Wishbone bridge and gives the SPI host a byte-stream mailbox into the FPGA fabric. It holds two synchronous FIFOs: RX (fabric → host, drained by Wishbone reads) and TX (host → fabric, filled by Wishbone writes). Status and fill counts are exposed as registers. Stream sides use valid/ready handshakes.

## Interface
- BASE_ADDR, 16'h0100, base of the 4-byte register window; bits [1:0] must be 0
- DEPTH_LOG2, 4, log2 of each FIFO depth (depth = 16); legal range 1..7
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- wb_adr_i  in  16  Wishbone address
- wb_dat_i  in  8  Wishbone write data
- wb_dat_o  out  8  Wishbone read data, valid while wb_ack_o=1
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle
- wb_stb_i  in  1  strobe
- wb_ack_o  out  1  single-cycle acknowledge
- rx_data_i  in  8  fabric byte into RX FIFO
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  RX FIFO not full
- tx_data_o  out  8  head of TX FIFO (first-word fall-through); 0x00 when tx_valid_o=0
- tx_valid_o  out  1  TX FIFO not empty
- tx_ready_i  in  1  fabric accepts tx_data_o

## Operation
- Selected when wb_cyc_i & wb_stb_i & (wb_adr_i[15:2] == BASE_ADDR[15:2]). Unselected cycles are ignored entirely: no ack, no side effects.
- Register map, offset = wb_adr_i[1:0]:
  - 0 DATA:
    - Read pops the RX FIFO. If RX is empty, returns 0x00 and sets RX_UNDERFLOW.
    - Write pushes the TX FIFO. If TX is full, the byte is dropped and TX_OVERFLOW is set.
  - 1 STATUS: bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 RX_UNDERFLOW (sticky), bit5 TX_OVERFLOW (sticky), bits7:6 = 0.
    - Writing 1 to bit4/bit5 clears that flag. Other bits are read-only.
  - 2 RX_COUNT: RX occupancy 0..DEPTH, zero-extended to 8 bits. Writes are ignored.
  - 3 TX_COUNT: TX occupancy, same format. Writes are ignored.
- Exactly one side effect per Wishbone transaction, applied in the cycle wb_ack_o is driven high.
- FIFO storage:
  - DEPTH entries, binary read/write pointers of DEPTH_LOG2 bits that wrap modulo DEPTH.
  - Count register is DEPTH_LOG2+1 bits.
  - full = (count == DEPTH); empty = (count == 0).
  - Storage is not reset.
- RX push when rx_valid_i & rx_ready_o. TX pop when tx_valid_o & tx_ready_i.
- Full/empty are evaluated from the count registered at the start of the cycle:
  - Simultaneous push+pop on a non-empty, non-full FIFO: both occur, count unchanged.
  - Empty RX, Wishbone DATA read + stream push in the same cycle: read underflows (returns 0x00, flag set); push succeeds; count becomes 1.
  - Full TX, Wishbone DATA write + stream pop in the same cycle: write is dropped (flag set); pop succeeds; count becomes DEPTH-1.
- Flag set and write-1-clear in the same cycle: set wins.
- Reset:
  - Pointers, counts and flags → 0.
  - wb_ack_o=0, wb_dat_o=0x00, tx_valid_o=0, tx_data_o=0x00, rx_ready_o=1 (first cycle after reset).
  - Reset mid-transaction abandons it: no ack, no side effect.

## Timing
- wb_ack_o rises in the cycle after selection is first seen (registered), for one cycle only.
  - The ack term includes !wb_ack_o, so a strobe held high through the ack cycle does not cause a second side effect.
  - Back-to-back selected strobes give at most one ack every 2 cycles.
- wb_dat_o is registered with the ack. It equals 0x00 whenever wb_ack_o=0.
  - STATUS/COUNT reads return the values in the selection cycle (pre-side-effect).
- rx_ready_o, tx_valid_o and tx_data_o are combinational from registered count/pointers. They change the cycle after a push or pop.
- Stream push to Wishbone visibility: a byte pushed in cycle N appears in RX_COUNT for a read selected in cycle N+1.
- Throughput: each stream side moves 1 byte/cycle while not blocked.

## Test plan
- Reset, then read STATUS → 0x05; RX_COUNT → 0x00; tx_valid_o=0; rx_ready_o=1.
- Push 0x11, 0x22, 0x33 on RX stream; read DATA three times → 0x11, 0x22, 0x33; fourth read → 0x00 with STATUS bit4=1; write STATUS 0x10 → bit4 clears.
- Write DATA 0xA0..0xAF (16 writes) with tx_ready_i=0: TX_COUNT=0x10, STATUS bit3=1. 17th write 0xFF is dropped and bit5=1. Raise tx_ready_i → 0xA0..0xAF emerge in order on consecutive cycles, then tx_valid_o=0.
- Fill RX to 16 → rx_ready_o=0; an extra rx_valid_i is not accepted. One DATA read → rx_ready_o=1 the next cycle; a pushed byte lands at the wrapped pointer and is read last in order.
- Simultaneous events:
  - Empty RX, DATA read and stream push in the same cycle → read data 0x00, RX_COUNT=1.
  - Full TX, DATA write and tx pop in the same cycle → TX_COUNT=15, bit5=1.
- Hold wb_stb_i high for 4 cycles on a DATA read → exactly one ack and one pop. An access to 0x0104 produces no ack. Asserting rst in the ack-pending cycle → no ack and counts = 0.

Source files
------------

// File: rtl/wb_stream_mailbox_if.sv
// -----------------------------------------------------------------------------
// wb_stream_mailbox_if
// Bundles the Wishbone slave bus and the two byte-stream handshakes of the
// SPI-host mailbox. Signal names keep their direction suffix as seen from the
// mailbox (slave) so the mapping to the block's port list is one-to-one.
//   Wishbone : wb_adr_i[15:0], wb_dat_i[7:0], wb_we_i, wb_cyc_i, wb_stb_i
//              -> wb_dat_o[7:0], wb_ack_o
//   RX stream: rx_data_i[7:0], rx_valid_i -> rx_ready_o   (fabric to host)
//   TX stream: tx_ready_i -> tx_data_o[7:0], tx_valid_o   (host to fabric)
// Modports: slave  = the mailbox
//           master = Wishbone host together with the fabric stream endpoints
// -----------------------------------------------------------------------------
interface wb_stream_mailbox_if;
    logic [15:0] wb_adr_i;
    logic [7:0]  wb_dat_i;
    logic [7:0]  wb_dat_o;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o,
        input  rx_data_i, rx_valid_i,
        output rx_ready_o,
        output tx_data_o, tx_valid_o,
        input  tx_ready_i
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o,
        output rx_data_i, rx_valid_i,
        input  rx_ready_o,
        input  tx_data_o, tx_valid_o,
        output tx_ready_i
    );
endinterface

// File: rtl/wb_stream_mailbox.sv
// -----------------------------------------------------------------------------
// wb_stream_mailbox
// Wishbone slave giving the SPI host a byte-stream mailbox into the fabric.
// RX FIFO: filled by the fabric stream, drained by Wishbone DATA reads.
// TX FIFO: filled by Wishbone DATA writes, drained by the fabric stream (FWFT).
// Register window at BASE_ADDR (offset = wb_adr_i[1:0]):
//   0 DATA      read pops RX / write pushes TX
//   1 STATUS    {2'b0, tx_overflow, rx_underflow, tx_full, tx_empty,
//                rx_full, rx_empty}; write 1 to bit4/bit5 clears the flag
//   2 RX_COUNT  RX occupancy (read only)
//   3 TX_COUNT  TX occupancy (read only)
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  wb_stream_mailbox_if.slave (Wishbone + RX/TX streams)
// Parameters:
//   BASE_ADDR   window base, bits [1:0] must be zero
//   DEPTH_LOG2  log2 of each FIFO depth, 1..7
// -----------------------------------------------------------------------------
module wb_stream_mailbox #(
    parameter logic [15:0] BASE_ADDR  = 16'h0100,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_stream_mailbox_if.slave   bus
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1'b1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1'b1);

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_RXCNT  = 2'd2;
    localparam logic [1:0] OFF_TXCNT  = 2'd3;

    // Storage arrays are intentionally left without reset.
    logic [7:0] rx_mem_q [DEPTH];
    logic [7:0] tx_mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic                  rx_uflow_q, rx_uflow_d, tx_oflow_q, tx_oflow_d;
    logic                  ack_q, ack_d, done_q, done_d;
    logic [7:0]            dat_q, dat_d;

    logic       sel_s, fire_s, data_rd_s, data_wr_s;
    logic       rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
    logic       rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
    logic       uflow_set_s, oflow_set_s, uflow_clr_s, oflow_clr_s;
    logic [7:0] status_s, rd_mux_s;

    // Status and stream handshakes derive from counts registered at cycle start.
    always_comb begin
        rx_empty_s = (rx_cnt_q == {(DEPTH_LOG2 + 1){1'b0}});
        rx_full_s  = (rx_cnt_q == CNT_FULL);
        tx_empty_s = (tx_cnt_q == {(DEPTH_LOG2 + 1){1'b0}});
        tx_full_s  = (tx_cnt_q == CNT_FULL);
        status_s   = {2'b00, tx_oflow_q, rx_uflow_q,
                      tx_full_s, tx_empty_s, rx_full_s, rx_empty_s};
    end

    // Transaction decode. A transaction fires once per strobe: after the ack,
    // done_q blocks re-triggering until the master releases the selection.
    always_comb begin
        sel_s       = bus.wb_cyc_i & bus.wb_stb_i &
                      (bus.wb_adr_i[15:2] == BASE_ADDR[15:2]);
        fire_s      = sel_s & ~ack_q & ~done_q;
        data_rd_s   = fire_s & ~bus.wb_we_i & (bus.wb_adr_i[1:0] == OFF_DATA);
        data_wr_s   = fire_s &  bus.wb_we_i & (bus.wb_adr_i[1:0] == OFF_DATA);
        rx_pop_s    = data_rd_s & ~rx_empty_s;
        uflow_set_s = data_rd_s &  rx_empty_s;
        tx_push_s   = data_wr_s & ~tx_full_s;
        oflow_set_s = data_wr_s &  tx_full_s;
        uflow_clr_s = fire_s & bus.wb_we_i &
                      (bus.wb_adr_i[1:0] == OFF_STATUS) & bus.wb_dat_i[4];
        oflow_clr_s = fire_s & bus.wb_we_i &
                      (bus.wb_adr_i[1:0] == OFF_STATUS) & bus.wb_dat_i[5];
        rx_push_s   = bus.rx_valid_i & ~rx_full_s;
        tx_pop_s    = bus.tx_ready_i & ~tx_empty_s;
    end

    // Read-data mux; values are those of the selection cycle (pre-side-effect).
    always_comb begin
        case (bus.wb_adr_i[1:0])
            OFF_DATA:   rd_mux_s = rx_empty_s ? 8'h00 : rx_mem_q[rx_rd_ptr_q];
            OFF_STATUS: rd_mux_s = status_s;
            OFF_RXCNT:  rd_mux_s = 8'(rx_cnt_q);
            OFF_TXCNT:  rd_mux_s = 8'(tx_cnt_q);
            default:    rd_mux_s = 8'h00;
        endcase
    end

    // Next state of the bus handshake registers.
    always_comb begin
        ack_d = fire_s;
        if (fire_s && !bus.wb_we_i) begin
            dat_d = rd_mux_s;
        end else begin
            dat_d = 8'h00;
        end
        if (sel_s) begin
            done_d = done_q | fire_s;
        end else begin
            done_d = 1'b0;
        end
    end

    // Next state of FIFO pointers, counts and sticky flags; flag set beats clear.
    always_comb begin
        rx_wr_ptr_d = rx_push_s ? (rx_wr_ptr_q + PTR_ONE) : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop_s  ? (rx_rd_ptr_q + PTR_ONE) : rx_rd_ptr_q;
        tx_wr_ptr_d = tx_push_s ? (tx_wr_ptr_q + PTR_ONE) : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop_s  ? (tx_rd_ptr_q + PTR_ONE) : tx_rd_ptr_q;

        if (rx_push_s && !rx_pop_s) begin
            rx_cnt_d = rx_cnt_q + CNT_ONE;
        end else if (!rx_push_s && rx_pop_s) begin
            rx_cnt_d = rx_cnt_q - CNT_ONE;
        end else begin
            rx_cnt_d = rx_cnt_q;
        end

        if (tx_push_s && !tx_pop_s) begin
            tx_cnt_d = tx_cnt_q + CNT_ONE;
        end else if (!tx_push_s && tx_pop_s) begin
            tx_cnt_d = tx_cnt_q - CNT_ONE;
        end else begin
            tx_cnt_d = tx_cnt_q;
        end

        rx_uflow_d = uflow_set_s | (rx_uflow_q & ~uflow_clr_s);
        tx_oflow_d = oflow_set_s | (tx_oflow_q & ~oflow_clr_s);
    end

    // Control/state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
            dat_q       <= 8'h00;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            tx_cnt_q    <= '0;
            rx_uflow_q  <= 1'b0;
            tx_oflow_q  <= 1'b0;
        end else begin
            ack_q       <= ack_d;
            done_q      <= done_d;
            dat_q       <= dat_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_uflow_q  <= rx_uflow_d;
            tx_oflow_q  <= tx_oflow_d;
        end
    end

    // FIFO storage writes; harmless during reset since pointers restart at 0.
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem_q[rx_wr_ptr_q] <= bus.rx_data_i;
        end
        if (tx_push_s) begin
            tx_mem_q[tx_wr_ptr_q] <= bus.wb_dat_i;
        end
    end

    assign bus.wb_ack_o   = ack_q;
    assign bus.wb_dat_o   = dat_q;
    assign bus.rx_ready_o = ~rx_full_s;
    assign bus.tx_valid_o = ~tx_empty_s;
    assign bus.tx_data_o  = tx_empty_s ? 8'h00 : tx_mem_q[tx_rd_ptr_q];

endmodule

// File: tb/tb_wb_stream_mailbox.sv
// -----------------------------------------------------------------------------
// tb_wb_stream_mailbox
// Directed self-checking bench for wb_stream_mailbox (BASE 0x0100, depth 16).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_wb_stream_mailbox;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    wb_stream_mailbox_if bus();

    wb_stream_mailbox #(.BASE_ADDR(16'h0100), .DEPTH_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] A_DATA   = 16'h0100;
    localparam logic [15:0] A_STATUS = 16'h0101;
    localparam logic [15:0] A_RXCNT  = 16'h0102;
    localparam logic [15:0] A_TXCNT  = 16'h0103;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One Wishbone access, waits up to 4 cycles for an ack, then one idle cycle.
    task automatic wb_xfer(input logic [15:0] adr, input logic we, input logic [7:0] wdat,
                           output logic [7:0] rdat, output logic acked);
        bus.wb_adr_i = adr;
        bus.wb_we_i  = we;
        bus.wb_dat_i = wdat;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        rdat  = 8'h00;
        acked = 1'b0;
        for (int i = 0; i < 4 && !acked; i++) begin
            tick();
            if (bus.wb_ack_o === 1'b1) begin
                acked = 1'b1;
                rdat  = bus.wb_dat_o;
            end
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        tick();
    endtask

    task automatic rx_push(input logic [7:0] d);
        bus.rx_data_i  = d;
        bus.rx_valid_i = 1'b1;
        tick();
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        logic       ak;
        bus.wb_adr_i = 16'h0000; bus.wb_dat_i = 8'h00; bus.wb_we_i = 1'b0;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        bus.rx_data_i = 8'h00; bus.rx_valid_i = 1'b0; bus.tx_ready_i = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        vectors++;
        if (bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 8'h00 || bus.tx_valid_o !== 1'b0 ||
            bus.tx_data_o !== 8'h00 || bus.rx_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_outputs: ack=%b dat=%h txv=%b txd=%h rxr=%b, want 0 00 0 00 1",
                     bus.wb_ack_o, bus.wb_dat_o, bus.tx_valid_o, bus.tx_data_o, bus.rx_ready_o);
        end
        wb_xfer(A_STATUS, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (ak !== 1'b1 || rd !== 8'h05) begin
            miscompares++; $display("FAIL reset_status: got %h ack %b, want 05", rd, ak);
        end
        wb_xfer(A_RXCNT, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (ak !== 1'b1 || rd !== 8'h00) begin
            miscompares++; $display("FAIL reset_rxcount: got %h ack %b, want 00", rd, ak);
        end
    endtask

    task automatic test_rx_fifo();
        logic [7:0] rd;
        logic       ak;
        logic [7:0] exp_b [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) rx_push(exp_b[i]);
        wb_xfer(A_RXCNT, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (ak !== 1'b1 || rd !== 8'h03) begin
            miscompares++; $display("FAIL rx_count3: got %h, want 03", rd);
        end
        for (int i = 0; i < 3; i++) begin
            wb_xfer(A_DATA, 1'b0, 8'h00, rd, ak);
            vectors++;
            if (ak !== 1'b1 || rd !== exp_b[i]) begin
                miscompares++; $display("FAIL rx_read%0d: got %h ack %b, want %h", i, rd, ak, exp_b[i]);
            end
        end
        wb_xfer(A_DATA, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (ak !== 1'b1 || rd !== 8'h00) begin
            miscompares++; $display("FAIL rx_underflow_data: got %h ack %b, want 00", rd, ak);
        end
        wb_xfer(A_STATUS, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h15) begin
            miscompares++; $display("FAIL rx_underflow_flag: got %h, want 15", rd);
        end
        wb_xfer(A_STATUS, 1'b1, 8'h10, rd, ak);
        wb_xfer(A_STATUS, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h05) begin
            miscompares++; $display("FAIL rx_underflow_clear: got %h, want 05", rd);
        end
    endtask

    task automatic test_tx_fill();
        logic [7:0] rd;
        logic       ak;
        bus.tx_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) wb_xfer(A_DATA, 1'b1, 8'hA0 + 8'(i), rd, ak);
        wb_xfer(A_TXCNT, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h10) begin
            miscompares++; $display("FAIL tx_count_full: got %h, want 10", rd);
        end
        wb_xfer(A_STATUS, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h09) begin
            miscompares++; $display("FAIL tx_status_full: got %h, want 09", rd);
        end
        wb_xfer(A_DATA, 1'b1, 8'hFF, rd, ak);
        wb_xfer(A_STATUS, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (ak !== 1'b1 || rd !== 8'h29) begin
            miscompares++; $display("FAIL tx_overflow_flag: got %h ack %b, want 29", rd, ak);
        end
        bus.tx_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'hA0 + 8'(i)) begin
                miscompares++;
                $display("FAIL tx_drain%0d: valid %b data %h, want 1 %h",
                         i, bus.tx_valid_o, bus.tx_data_o, 8'hA0 + 8'(i));
            end
            tick();
        end
        vectors++;
        if (bus.tx_valid_o !== 1'b0 || bus.tx_data_o !== 8'h00) begin
            miscompares++;
            $display("FAIL tx_drained: valid %b data %h, want 0 00", bus.tx_valid_o, bus.tx_data_o);
        end
        bus.tx_ready_i = 1'b0;
        wb_xfer(A_STATUS, 1'b1, 8'h20, rd, ak);
        wb_xfer(A_STATUS, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h05) begin
            miscompares++; $display("FAIL tx_overflow_clear: got %h, want 05", rd);
        end
    endtask

    task automatic test_rx_wrap();
        logic [7:0] rd;
        logic       ak;
        for (int i = 0; i < 16; i++) rx_push(8'hB0 + 8'(i));
        vectors++;
        if (bus.rx_ready_o !== 1'b0) begin
            miscompares++; $display("FAIL rx_full_ready: got %b, want 0", bus.rx_ready_o);
        end
        rx_push(8'hEE);
        wb_xfer(A_RXCNT, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h10) begin
            miscompares++; $display("FAIL rx_full_count: got %h, want 10", rd);
        end
        wb_xfer(A_STATUS, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h06) begin
            miscompares++; $display("FAIL rx_full_status: got %h, want 06", rd);
        end
        wb_xfer(A_DATA, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'hB0 || bus.rx_ready_o !== 1'b1) begin
            miscompares++; $display("FAIL rx_wrap_first: got %h ready %b, want B0 1", rd, bus.rx_ready_o);
        end
        rx_push(8'hC0);
        for (int i = 1; i < 17; i++) begin
            logic [7:0] want;
            want = (i == 16) ? 8'hC0 : 8'hB0 + 8'(i);
            wb_xfer(A_DATA, 1'b0, 8'h00, rd, ak);
            vectors++;
            if (ak !== 1'b1 || rd !== want) begin
                miscompares++; $display("FAIL rx_wrap_read%0d: got %h, want %h", i, rd, want);
            end
        end
        wb_xfer(A_RXCNT, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h00) begin
            miscompares++; $display("FAIL rx_wrap_empty: got %h, want 00", rd);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] rd;
        logic       ak;
        // Empty RX: DATA read and stream push in the same cycle.
        bus.wb_adr_i = A_DATA; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        bus.rx_data_i = 8'h5A; bus.rx_valid_i = 1'b1;
        tick();
        bus.rx_valid_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        vectors++;
        if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 8'h00) begin
            miscompares++;
            $display("FAIL sim_rx_read: ack %b data %h, want 1 00", bus.wb_ack_o, bus.wb_dat_o);
        end
        tick();
        wb_xfer(A_RXCNT, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h01) begin
            miscompares++; $display("FAIL sim_rx_count: got %h, want 01", rd);
        end
        wb_xfer(A_STATUS, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h14) begin
            miscompares++; $display("FAIL sim_rx_status: got %h, want 14", rd);
        end
        wb_xfer(A_DATA, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h5A) begin
            miscompares++; $display("FAIL sim_rx_data: got %h, want 5A", rd);
        end
        wb_xfer(A_STATUS, 1'b1, 8'h10, rd, ak);
        // Full TX: DATA write and stream pop in the same cycle.
        for (int i = 0; i < 16; i++) wb_xfer(A_DATA, 1'b1, 8'hC0 + 8'(i), rd, ak);
        bus.wb_adr_i = A_DATA; bus.wb_we_i = 1'b1; bus.wb_dat_i = 8'h77;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.tx_ready_i = 1'b1;
        tick();
        bus.tx_ready_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        vectors++;
        if (bus.wb_ack_o !== 1'b1 || bus.tx_data_o !== 8'hC1) begin
            miscompares++;
            $display("FAIL sim_tx_ack: ack %b head %h, want 1 C1", bus.wb_ack_o, bus.tx_data_o);
        end
        tick();
        wb_xfer(A_TXCNT, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h0F) begin
            miscompares++; $display("FAIL sim_tx_count: got %h, want 0F", rd);
        end
        wb_xfer(A_STATUS, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h21) begin
            miscompares++; $display("FAIL sim_tx_status: got %h, want 21", rd);
        end
        bus.tx_ready_i = 1'b1;
        for (int i = 1; i < 16; i++) begin
            vectors++;
            if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'hC0 + 8'(i)) begin
                miscompares++;
                $display("FAIL sim_tx_drain%0d: data %h, want %h", i, bus.tx_data_o, 8'hC0 + 8'(i));
            end
            tick();
        end
        bus.tx_ready_i = 1'b0;
        vectors++;
        if (bus.tx_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL sim_tx_empty: valid %b, want 0", bus.tx_valid_o);
        end
        wb_xfer(A_STATUS, 1'b1, 8'h20, rd, ak);
    endtask

    task automatic test_strobe_hold();
        logic [7:0] rd;
        logic       ak;
        int         acks;
        logic [7:0] first;
        rx_push(8'h66);
        rx_push(8'h67);
        acks = 0;
        first = 8'h00;
        bus.wb_adr_i = A_DATA; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.wb_ack_o === 1'b1) begin
                if (acks == 0) first = bus.wb_dat_o;
                acks++;
            end
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        tick();
        vectors++;
        if (acks != 1 || first !== 8'h66) begin
            miscompares++; $display("FAIL hold_acks: got %0d acks data %h, want 1 66", acks, first);
        end
        wb_xfer(A_RXCNT, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h01) begin
            miscompares++; $display("FAIL hold_pops: count %h, want 01", rd);
        end
        wb_xfer(A_DATA, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h67) begin
            miscompares++; $display("FAIL hold_next: got %h, want 67", rd);
        end
    endtask

    task automatic test_unselected();
        logic [7:0] rd;
        logic       ak;
        wb_xfer(16'h0104, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (ak !== 1'b0) begin
            miscompares++; $display("FAIL unsel_read_ack: got %b, want 0", ak);
        end
        wb_xfer(16'h0104, 1'b1, 8'h42, rd, ak);
        wb_xfer(A_TXCNT, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h00 || bus.tx_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL unsel_write: count %h valid %b, want 00 0", rd, bus.tx_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd;
        logic       ak;
        rx_push(8'h01);
        rx_push(8'h02);
        wb_xfer(A_DATA, 1'b1, 8'h31, rd, ak);
        bus.wb_adr_i = A_DATA; bus.wb_we_i = 1'b1; bus.wb_dat_i = 8'h99;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        vectors++;
        if (bus.wb_ack_o !== 1'b0 || bus.tx_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_ack: ack %b txv %b, want 0 0", bus.wb_ack_o, bus.tx_valid_o);
        end
        tick();
        wb_xfer(A_RXCNT, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h00) begin
            miscompares++; $display("FAIL rstmid_rxcount: got %h, want 00", rd);
        end
        wb_xfer(A_TXCNT, 1'b0, 8'h00, rd, ak);
        vectors++;
        if (rd !== 8'h00) begin
            miscompares++; $display("FAIL rstmid_txcount: got %h, want 00", rd);
        end
    endtask

    initial begin
        test_reset();
        test_rx_fifo();
        test_tx_fill();
        test_rx_wrap();
        test_simultaneous();
        test_strobe_hold();
        test_unselected();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
